mult_scheduler: RTL and testbench
=================================

// Module: mult_scheduler
// PURPOSE
//  Shares one combinational SIZE x SIZE multiplier among NUM_REQ requesters.
//  Requesters are served by round-robin arbitration, one operation at a time.
//  Operands are registered and held on the multiplier inputs for MUL_CYCLES
//  cycles (multicycle path), then the product is registered and returned.
//  Sits between the ALU issue logic and the shared multiplier instance.
// PARAMETERS
//  SIZE        8  operand width; product width is 2*SIZE
//  NUM_REQ     4  number of requesters (>=2)
//  MUL_CYCLES  2  cycles operands are held before product capture (>=1)
//  ID_W        $clog2(NUM_REQ)  requester-id width (localparam)
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  req_valid    in   NUM_REQ       per-requester operation request
//  req_ready    out  NUM_REQ       one-hot accept; handshake = valid & ready
//  req_a        in   NUM_REQ*SIZE  operand a; requester i uses [i*SIZE +: SIZE]
//  req_b        in   NUM_REQ*SIZE  operand b, same packing as req_a
//  mul_a        out  SIZE          registered operand to shared multiplier
//  mul_b        out  SIZE          registered operand to shared multiplier
//  mul_c        in   2*SIZE        product from shared multiplier
//  rsp_valid    out  1             result available
//  rsp_ready    in   1             result consumer accepts
//  rsp_id       out  ID_W          index of the requester owning the result
//  rsp_product  out  2*SIZE        registered product
//  busy         out  1             high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; req_ready, mul_a, mul_b, rsp_valid,
//   rsp_id, rsp_product and busy all 0; last_grant=NUM_REQ-1.
//   Any in-flight operation is dropped. No response is produced for it.
//  FSM IDLE -> CALC -> RESP -> IDLE.
//  IDLE: grant g = first i with req_valid[i], searching from last_grant+1 (mod
//   NUM_REQ). req_ready[g]=1 combinationally in the same cycle; all other
//   req_ready bits are 0. req_ready is 0 in every state except IDLE. On the
//   edge: mul_a/mul_b <= req_a/req_b slice g, rsp_id <= g, last_grant <= g,
//   cnt <= MUL_CYCLES-1, goto CALC. No req_valid: stay IDLE.
//  CALC: mul_a/mul_b are held stable. If cnt==0, rsp_product <= mul_c and
//   goto RESP; otherwise cnt <= cnt-1. CALC lasts exactly MUL_CYCLES cycles.
//  RESP: rsp_valid=1. rsp_id and rsp_product are stable until handshake.
//   On rsp_ready=1, goto IDLE; rsp_valid falls on the next cycle.
//   rsp_ready is ignored outside RESP.
//  Latency: accept edge T -> rsp_valid high from T+MUL_CYCLES+1.
//   Peak throughput is 1 op per MUL_CYCLES+2 cycles, because RESP->IDLE costs
//   one arbitration cycle.
//  Arithmetic: unsigned; product = a*b exactly, no truncation in 2*SIZE bits.
//  Requesters that drop req_valid before grant lose nothing: no request is
//   stored. Operands must be valid only in the grant cycle.
//  Simultaneous requests: exactly one is granted per IDLE cycle. The others
//   keep req_valid high and wait.
//  Fairness: a requester with continuous req_valid is granted within NUM_REQ
//   operations.
//  mul_a/mul_b keep the last operands after RESP. They change only on grant.
// TESTING (SIZE=8, NUM_REQ=4, MUL_CYCLES=2, rsp_ready=1 unless stated)
//  1 req0 a=13 b=11, grant at T -> rsp_valid at T+3, rsp_id=0, product=143.
//  2 All four req_valid high continuously -> grant order 0,1,2,3,0. Each rsp_id
//    matches its grant; products correct for distinct operands.
//  3 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_product stable.
//    req_ready stays all-0, busy=1. Release -> IDLE on the next cycle.
//  4 Boundaries: 255*255 -> 16'hFE01; 0*200 -> 0; 1*255 -> 255; 128*2 -> 256.
//  5 rst_n low in CALC -> all outputs 0 immediately. No response is produced.
//    After release, req0 and req2 both valid -> req0 granted first.
//  6 req1 and req3 held valid -> grants alternate 1,3,1,3. req0/req2 are
//    never readied.

Source files
------------

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin front end for one shared combinational
// multiplier. A single operation is in flight at a time. The operands are
// registered and held on mul_a/mul_b for MUL_CYCLES cycles, which lets the
// multiplier be timed as a multicycle path. The product is then registered
// and held until the consumer accepts it.
module mult_scheduler #(
  parameter  int SIZE       = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MUL_CYCLES = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SIZE-1:0]   req_a,
  input  logic [NUM_REQ*SIZE-1:0]   req_b,
  output logic [SIZE-1:0]           mul_a,
  output logic [SIZE-1:0]           mul_b,
  input  logic [2*SIZE-1:0]         mul_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*SIZE-1:0]         rsp_product,
  output logic                      busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ID_W-1:0]   last_grant_reg;
  logic [SIZE-1:0]   mul_a_reg;
  logic [SIZE-1:0]   mul_b_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [2*SIZE-1:0] rsp_product_reg;

  logic [ID_W-1:0]   grant;
  logic              grant_found;
  logic [ID_W-1:0]   scan_id;
  int                scan_idx;
  logic              load;
  logic              capture;

  // Unpack the flat operand buses into per-requester words
  logic [SIZE-1:0] a_arr [NUM_REQ];
  logic [SIZE-1:0] b_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*SIZE +: SIZE];
      assign b_arr[gi] = req_b[gi*SIZE +: SIZE];
    end
  endgenerate

  // Round-robin search: first valid requester after the last one granted
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    scan_id     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(last_grant_reg) + 1 + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_id = ID_W'(scan_idx);
      if (!grant_found && req_valid[scan_id]) begin
        grant       = scan_id;
        grant_found = 1'b1;
      end
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    load       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant] = 1'b1;
          load             = 1'b1;
          state_next       = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand/result datapath: load on grant, count down in CALC, capture product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      last_grant_reg  <= LAST_INIT;
      mul_a_reg       <= '0;
      mul_b_reg       <= '0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
    end else begin
      if (load) begin
        mul_a_reg      <= a_arr[grant];
        mul_b_reg      <= b_arr[grant];
        rsp_id_reg     <= grant;
        last_grant_reg <= grant;
        cnt_reg        <= CNT_INIT;
      end else if (state_reg == CALC && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (capture) begin
        rsp_product_reg <= mul_c;
      end
    end
  end

  assign mul_a       = mul_a_reg;
  assign mul_b       = mul_b_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_product = rsp_product_reg;
  assign rsp_valid   = (state_reg == RESP);
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: drives mult_scheduler with a behavioural multiplier on
// mul_a/mul_b. A cycle-timeline reference model checks every cycle. On top of
// that run a vector table, hand-written corner sequences and a random phase.
module tb_mult_scheduler;

  localparam int SIZE       = 8;
  localparam int NUM_REQ    = 4;
  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_c;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        busy;

  mult_scheduler #(.SIZE(SIZE), .NUM_REQ(NUM_REQ), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared multiplier being scheduled
  assign mul_c = {8'b0, mul_a} * {8'b0, mul_b};

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model: timeline of when the block is free and when a result is due
  int          cyc = 0;
  int          m_last = NUM_REQ - 1;
  int          m_free_at = 0;
  int          m_ready_at = 0;
  bit          m_pend = 1'b0;
  int          m_id = 0;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod;
  int          dut_grants[$];
  int          hs_cnt = 0;
  int          hs_id = 0;
  int          hs_cyc = 0;
  int          gr_cyc = 0;
  logic [15:0] hs_prod = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input logic rr);
    int         g;
    int         idx;
    logic [3:0] exp_ready;
    logic       exp_valid;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_last + 1 + k) % NUM_REQ;
      if (g < 0 && v[idx]) g = idx;
    end
    if (cyc < m_free_at) g = -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(cyc < m_free_at));
    exp_valid = m_pend && (cyc >= m_ready_at);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_product", 32'(rsp_product), 32'(m_prod));
      chk("mul_a_held", 32'(mul_a), 32'(m_a));
      chk("mul_b_held", 32'(mul_b), 32'(m_b));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) dut_grants.push_back(k);
    end
    if (exp_valid && rr) begin
      hs_cnt++; hs_prod = rsp_product; hs_id = int'(rsp_id); hs_cyc = cyc;
      $display("rsp id=%0d a=%0d b=%0d product=%0d cycle=%0d", rsp_id, m_a, m_b, rsp_product, cyc);
      m_pend = 1'b0;
      m_free_at = cyc + 1;
    end
    if (g >= 0) begin
      m_a = a[g*8 +: 8];
      m_b = b[g*8 +: 8];
      m_prod = {8'b0, m_a} * {8'b0, m_b};
      m_id = g; m_pend = 1'b1;
      m_ready_at = cyc + MUL_CYCLES + 1;
      m_free_at = 1 << 30;
      m_last = g; gr_cyc = cyc;
    end
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_product", 32'(rsp_product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NUM_REQ - 1; m_pend = 1'b0; m_free_at = 0; cyc = 0;
    dut_grants.delete();
  endtask

  // Grant one requester alone and wait for its response
  task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod);
    logic [31:0] aa, bb;
    int          start_hs, n_gr, t;
    aa = $urandom; bb = $urandom;
    aa[id*8 +: 8] = a; bb[id*8 +: 8] = b;
    start_hs = hs_cnt; n_gr = dut_grants.size(); t = 0;
    while (dut_grants.size() == n_gr && t < 8) begin
      step(4'(1 << id), aa, bb, 1'b1); t++;
    end
    while (hs_cnt == start_hs && t < 20) begin
      step(4'h0, $urandom, $urandom, 1'b1); t++;
    end
    if (hs_cnt == start_hs) begin
      chk("vec_timeout", 32'd0, 32'd1);
    end else begin
      chk("vec_product", 32'(hs_prod), 32'(prod));
      chk("vec_id", 32'(hs_id), 32'(id));
      chk("vec_latency", 32'(hs_cyc - gr_cyc), 32'(MUL_CYCLES + 1));
    end
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  task automatic test_table();
    vec_t vecs[8];
    vecs[0] = '{0, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{1, 8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{2, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{3, 8'd1,   8'd255, 16'd255};
    vecs[4] = '{0, 8'd128, 8'd2,   16'd256};
    vecs[5] = '{3, 8'd200, 8'd0,   16'd0};
    vecs[6] = '{1, 8'd17,  8'd15,  16'd255};
    vecs[7] = '{2, 8'd100, 8'd100, 16'd10000};
    for (int i = 0; i < 8; i++) run_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].prod);
  endtask

  task automatic check_order(input string name, input int exp_q[$]);
    if (dut_grants.size() < exp_q.size()) chk({name, "_count"}, 32'(dut_grants.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dut_grants.size(); i++)
      chk(name, 32'(dut_grants[i]), 32'(exp_q[i]));
  endtask

  task automatic test_all_four();
    int exp_q[$];
    do_reset();
    for (int i = 0; i < 22; i++) step(4'hF, $urandom, $urandom, 1'b1);
    exp_q = '{0, 1, 2, 3, 0};
    check_order("order_all4", exp_q);
  endtask

  task automatic test_stall();
    int start_hs;
    do_reset();
    step(4'b0100, 32'h00_2A_00_00, 32'h00_07_00_00, 1'b1);
    start_hs = hs_cnt;
    for (int i = 0; i < MUL_CYCLES + 5; i++) step(4'hF, $urandom, $urandom, 1'b0);
    chk("stall_no_hs", 32'(hs_cnt), 32'(start_hs));
    step(4'h0, $urandom, $urandom, 1'b1);
    chk("stall_hs", 32'(hs_cnt), 32'(start_hs + 1));
    chk("stall_product", 32'(hs_prod), 32'd294);
    step(4'h0, $urandom, $urandom, 1'b1);
  endtask

  task automatic test_reset_in_calc();
    int exp_q[$];
    int start_hs;
    do_reset();
    step(4'b0001, 32'h0000_0033, 32'h0000_0044, 1'b1);
    do_reset();
    start_hs = hs_cnt;
    for (int i = 0; i < 6; i++) step(4'b0101, 32'h0009_0005, 32'h0003_0007, 1'b1);
    exp_q = '{0};
    check_order("rst_first_grant", exp_q);
    chk("rst_resp_count", 32'(hs_cnt - start_hs), 32'd1);
    chk("rst_resp_product", 32'(hs_prod), 32'd35);
  endtask

  task automatic test_alternate();
    int exp_q[$];
    do_reset();
    for (int i = 0; i < 18; i++) step(4'b1010, $urandom, $urandom, 1'b1);
    exp_q = '{1, 3, 1, 3};
    check_order("order_1_3", exp_q);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    do_reset();
    test_table();
    test_all_four();
    test_stall();
    test_reset_in_calc();
    test_alternate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
